cz_flag_scoreboard: RTL and testbench
=====================================

Name: cz_flag_scoreboard

Overview:
- Sequences conditional register writeback for ADC/ADZ-class ops in the pipelined core.
- Holds the architectural carry (C) and zero (Z) flags and scoreboards in-flight flag producers.
- Stalls decode while an op depends on a pending flag.
- Queues each issued op's write decision in order and releases it at completion, with the flag update gated by that decision.

Parameters:
- DEPTH, 4, max in-flight ops; power of 2, >=2.
- PTR_W, 2, log2(DEPTH).
- CNT_W, 3, pending-counter width; must hold DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode presents an op.
- id_cz_op  in  2  00 unconditional; 10 write if C; 01 write if Z; 11 never write.
- id_reg_wr  in  1  default reg-write for cz_op=00.
- id_c_wr  in  1  op updates C when executed.
- id_z_wr  in  1  op updates Z when executed.
- id_ready  out  1  issue accepted this cycle when id_valid&id_ready.
- ex_valid  in  1  in-order completion of FIFO-head op.
- ex_c  in  1  carry result.
- ex_z  in  1  zero result.
- wb_valid  out  1  registered completion pulse.
- wb_reg_wr  out  1  registered final register-write enable.
- c_flag  out  1  architectural C.
- z_flag  out  1  architectural Z.
- full  out  1  FIFO holds DEPTH entries.
- err_underflow  out  1  sticky; ex_valid seen with FIFO empty.

Behaviour:
- Reset (async, immediate): C=0, Z=0, FIFO empty, both pending counters 0, wb_valid=0, wb_reg_wr=0, err_underflow=0. In-flight ops are discarded; ex_valid in the cycle after reset deassert with an empty FIFO sets err_underflow.
- Pending counters: c_pend and z_pend count issued, executed entries with c_wr or z_wr set that have not yet completed.
- Hazard: id_ready=0 when full, or cz_op=10 and c_pend!=0, or cz_op=01 and z_pend!=0. cz_op 00 and 11 stall only on full.
- Issue decision, using current C/Z registers:
  - exec = cz_op==00 ? 1 : cz_op==10 ? C : cz_op==01 ? Z : 0.
  - wr = cz_op==00 ? id_reg_wr : exec.
  - Push entry {wr, exec&id_c_wr, exec&id_z_wr}.
  - c_pend += exec&id_c_wr; z_pend += exec&id_z_wr.
- Completion (ex_valid, FIFO non-empty):
  - Pop head.
  - Next cycle: wb_valid=1, wb_reg_wr=entry.wr.
  - If entry.cw: C<=ex_c, c_pend-=1. If entry.zw: Z<=ex_z, z_pend-=1.
- Completion with FIFO empty: no pop, no flag change, wb_valid=0, err_underflow<=1 (cleared only by reset).
- Simultaneous issue and completion: push and pop both occur; occupancy unchanged; counters apply +inc-dec in the same cycle.
- Simultaneous issue and completion when full: id_ready stays 0 (no bypass of full).
- Issue decision uses pre-update flags: a completion in the same cycle is not visible (except under FLAG_BYPASS_EN).
- Pointers wrap modulo DEPTH; full/empty are derived from a count register of PTR_W+1 bits.
- wb_valid is a 1-cycle pulse per completion; wb_reg_wr=0 whenever wb_valid=0.

Optional Feature:
- Macro: FLAG_BYPASS_EN.
- Defined:
  - If ex_valid retires the last pending producer of the needed flag (pend==1, head writes it), the hazard is lifted that cycle.
  - exec uses ex_c/ex_z in place of the register value.
  - For cz_op=00/11, exec/wr use the bypassed flag only where relevant (none).
- Undefined: a dependent op waits one extra cycle after the producing completion.

Test Plan:
- Reset, then issue cz_op=00, id_reg_wr=1, c_wr=1; ex_valid with ex_c=1 -> next cycle wb_valid=1, wb_reg_wr=1, c_flag=1, c_pend returns to 0.
- C=0, issue cz_op=10 (c_wr=1, z_wr=1); complete with ex_c=1, ex_z=1 -> wb_reg_wr=0, C stays 0, Z stays 0.
- Issue C-producer, then cz_op=10 op -> id_ready=0 until the producer completes; without bypass, accepted the cycle after completion; with FLAG_BYPASS_EN, accepted in the completion cycle.
- Issue 4 ops with no completion -> full=1, id_ready=0; issue and ex_valid in the same cycle -> still no push; next cycle push accepted.
- ex_valid with FIFO empty -> err_underflow=1, flags unchanged, wb_valid=0; stays 1 until reset.
- Assert reset with 3 ops in flight and c_pend=2 -> all outputs zero immediately; a dependent cz_op=10 is accepted on the first cycle after reset release.

Source files
------------

// File: rtl/cz_flag_scoreboard_if.sv
// Decode/execute/writeback handshake bundle for cz_flag_scoreboard.
// master = pipeline side driving decode and completion, slave = scoreboard.
interface cz_flag_scoreboard_if;
    logic       id_valid;
    logic [1:0] id_cz_op;
    logic       id_reg_wr;
    logic       id_c_wr;
    logic       id_z_wr;
    logic       id_ready;
    logic       ex_valid;
    logic       ex_c;
    logic       ex_z;
    logic       wb_valid;
    logic       wb_reg_wr;

    modport master (
        output id_valid, id_cz_op, id_reg_wr, id_c_wr, id_z_wr,
        output ex_valid, ex_c, ex_z,
        input  id_ready, wb_valid, wb_reg_wr
    );

    modport slave (
        input  id_valid, id_cz_op, id_reg_wr, id_c_wr, id_z_wr,
        input  ex_valid, ex_c, ex_z,
        output id_ready, wb_valid, wb_reg_wr
    );
endinterface

// File: rtl/cz_flag_scoreboard.sv
// Carry/zero flag scoreboard with an in-order write-decision FIFO for ADC/ADZ-class ops.
// Optional macro FLAG_BYPASS_EN forwards a completing flag result straight into issue.
module cz_flag_scoreboard #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int CNT_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    cz_flag_scoreboard_if.slave   bus,
    output logic                  c_flag,
    output logic                  z_flag,
    output logic                  full,
    output logic                  err_underflow
);

    typedef struct packed {
        logic wr;
        logic cw;
        logic zw;
    } entry_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    entry_t             fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic [CNT_W-1:0]   c_pend;
    logic [CNT_W-1:0]   z_pend;
    logic               wb_valid_q;
    logic               wb_reg_wr_q;

    logic               empty;
    logic               do_pop;
    logic               do_push;
    logic               pop_cw;
    logic               pop_zw;
    logic               eff_c;
    logic               eff_z;
    logic               c_busy;
    logic               z_busy;
    logic               hazard;
    logic               exec;
    entry_t             head;
    entry_t             push_entry;

    always_comb begin
        empty  = (count == '0);
        full   = (count == FULL_CNT);
        head   = fifo_mem[rd_ptr];
        do_pop = bus.ex_valid && !empty;
        pop_cw = do_pop && head.cw;
        pop_zw = do_pop && head.zw;
`ifdef FLAG_BYPASS_EN
        // A retiring producer counts as already done, so its result feeds issue directly.
        eff_c  = pop_cw ? bus.ex_c : c_flag;
        eff_z  = pop_zw ? bus.ex_z : z_flag;
        c_busy = (c_pend != CNT_W'(pop_cw));
        z_busy = (z_pend != CNT_W'(pop_zw));
`else
        eff_c  = c_flag;
        eff_z  = z_flag;
        c_busy = (c_pend != '0);
        z_busy = (z_pend != '0);
`endif
        hazard = ((bus.id_cz_op == 2'b10) && c_busy) ||
                 ((bus.id_cz_op == 2'b01) && z_busy);
        // Full always stalls, even when a completion frees a slot this cycle.
        bus.id_ready = !full && !hazard;
        do_push      = bus.id_valid && bus.id_ready;

        unique case (bus.id_cz_op)
            2'b00:   exec = 1'b1;
            2'b10:   exec = eff_c;
            2'b01:   exec = eff_z;
            default: exec = 1'b0;
        endcase
        push_entry.wr = (bus.id_cz_op == 2'b00) ? bus.id_reg_wr : exec;
        push_entry.cw = exec && bus.id_c_wr;
        push_entry.zw = exec && bus.id_z_wr;

        bus.wb_valid  = wb_valid_q;
        bus.wb_reg_wr = wb_reg_wr_q;
    end

    // Entry storage needs no reset; validity comes from count and the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            c_pend        <= '0;
            z_pend        <= '0;
            c_flag        <= 1'b0;
            z_flag        <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_reg_wr_q   <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count  <= count + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
            c_pend <= c_pend + CNT_W'(push_entry.cw && do_push) - CNT_W'(pop_cw);
            z_pend <= z_pend + CNT_W'(push_entry.zw && do_push) - CNT_W'(pop_zw);
            if (pop_cw) begin
                c_flag <= bus.ex_c;
            end
            if (pop_zw) begin
                z_flag <= bus.ex_z;
            end
            wb_valid_q  <= do_pop;
            wb_reg_wr_q <= do_pop && head.wr;
            if (bus.ex_valid && empty) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cz_flag_scoreboard.sv
// Self-checking bench for cz_flag_scoreboard: directed scenarios plus a random run
// compared against a queue-based model of the flag scoreboard.
module tb_cz_flag_scoreboard;

    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    logic c_flag;
    logic z_flag;
    logic full;
    logic err_underflow;

    cz_flag_scoreboard_if bus ();

    cz_flag_scoreboard #(.DEPTH(DEPTH), .PTR_W(2), .CNT_W(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .c_flag        (c_flag),
        .z_flag        (z_flag),
        .full          (full),
        .err_underflow (err_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Model: queue of in-flight entries {wr, cw, zw} plus architectural state.
    logic [2:0] m_q[$];
    bit   m_c, m_z, m_err, m_wbv, m_wbw;
    bit   exp_ready, exp_full;
    logic obs_ready, obs_full;

    function automatic int pend_c();
        int n = 0;
        foreach (m_q[i]) if (m_q[i][1]) n++;
        return n;
    endfunction

    function automatic int pend_z();
        int n = 0;
        foreach (m_q[i]) if (m_q[i][0]) n++;
        return n;
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_c = 0; m_z = 0; m_err = 0; m_wbv = 0; m_wbw = 0;
    endtask

    // Drive one cycle, sample the combinational handshake, advance the model, cross the edge.
    task automatic step(input bit v, input bit [1:0] op, input bit rw, input bit cw,
                        input bit zw, input bit exv, input bit exc, input bit exz);
        bit [2:0] head;
        bit pop, push, effc, effz, exec, wr;
        int pc, pz;
        bus.id_valid = v; bus.id_cz_op = op; bus.id_reg_wr = rw;
        bus.id_c_wr = cw; bus.id_z_wr = zw;
        bus.ex_valid = exv; bus.ex_c = exc; bus.ex_z = exz;
        #1;
        obs_ready = bus.id_ready;
        obs_full  = full;
        pop  = exv && (m_q.size() > 0);
        head = pop ? m_q[0] : 3'b000;
        pc = pend_c(); pz = pend_z();
        effc = m_c; effz = m_z;
`ifdef FLAG_BYPASS_EN
        if (pop && head[1]) begin pc--; effc = exc; end
        if (pop && head[0]) begin pz--; effz = exz; end
`endif
        exp_full  = (m_q.size() == DEPTH);
        exp_ready = !exp_full && !((op == 2'b10 && pc != 0) || (op == 2'b01 && pz != 0));
        push = v && exp_ready;
        exec = (op == 2'b00) ? 1'b1 : (op == 2'b10) ? effc : (op == 2'b01) ? effz : 1'b0;
        wr   = (op == 2'b00) ? rw : exec;
        m_wbv = pop;
        m_wbw = pop && head[2];
        if (pop) begin
            void'(m_q.pop_front());
            if (head[1]) m_c = exc;
            if (head[0]) m_z = exz;
        end else if (exv) begin
            m_err = 1;
        end
        if (push) m_q.push_back({wr, exec & cw, exec & zw});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.id_valid = 0; bus.id_cz_op = 0; bus.id_reg_wr = 0; bus.id_c_wr = 0;
        bus.id_z_wr = 0; bus.ex_valid = 0; bus.ex_c = 0; bus.ex_z = 0;
        reset = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < DEPTH + 2 && m_q.size() > 0; k++) step(0, 2'b00, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (c_flag !== 1'b0) begin errors++; $display("[TB] FAIL reset_c: got %b expected 0", c_flag); end
        checks++; if (z_flag !== 1'b0) begin errors++; $display("[TB] FAIL reset_z: got %b expected 0", z_flag); end
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_wbv: got %b expected 0", bus.wb_valid); end
        checks++; if (full !== 1'b0 || err_underflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_full_err: got %b%b expected 00", full, err_underflow); end
        checks++; if (bus.id_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.id_ready); end
    endtask

    task automatic test_uncond_write();
        do_reset();
        step(1, 2'b00, 1, 1, 0, 0, 0, 0);
        step(0, 2'b00, 0, 0, 0, 1, 1, 0);
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_reg_wr !== 1'b1) begin errors++; $display("[TB] FAIL uncond_wb: got v=%b w=%b expected v=1 w=1", bus.wb_valid, bus.wb_reg_wr); end
        checks++; if (c_flag !== 1'b1) begin errors++; $display("[TB] FAIL uncond_c: got %b expected 1", c_flag); end
        step(0, 2'b10, 0, 0, 0, 0, 0, 0);
        checks++; if (obs_ready !== 1'b1) begin errors++; $display("[TB] FAIL uncond_pend_clear: got ready %b expected 1", obs_ready); end
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL uncond_pulse: got wb_valid %b expected 0", bus.wb_valid); end
    endtask

    task automatic test_cond_skip();
        do_reset();
        step(1, 2'b10, 1, 1, 1, 0, 0, 0);
        step(0, 2'b00, 0, 0, 0, 1, 1, 1);
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_reg_wr !== 1'b0) begin errors++; $display("[TB] FAIL skip_wb: got v=%b w=%b expected v=1 w=0", bus.wb_valid, bus.wb_reg_wr); end
        checks++; if (c_flag !== 1'b0 || z_flag !== 1'b0) begin errors++; $display("[TB] FAIL skip_flags: got c=%b z=%b expected 0 0", c_flag, z_flag); end
    endtask

    task automatic test_hazard();
        do_reset();
        step(1, 2'b00, 1, 1, 0, 0, 0, 0);
        step(1, 2'b10, 1, 0, 0, 0, 0, 0);
        checks++; if (obs_ready !== 1'b0) begin errors++; $display("[TB] FAIL hazard_stall: got ready %b expected 0", obs_ready); end
        step(1, 2'b10, 1, 0, 0, 1, 1, 0);
`ifdef FLAG_BYPASS_EN
        checks++; if (obs_ready !== 1'b1) begin errors++; $display("[TB] FAIL hazard_bypass: got ready %b expected 1", obs_ready); end
`else
        checks++; if (obs_ready !== 1'b0) begin errors++; $display("[TB] FAIL hazard_complete_cycle: got ready %b expected 0", obs_ready); end
`endif
        step(1, 2'b10, 1, 0, 0, 0, 0, 0);
        checks++; if (obs_ready !== 1'b1) begin errors++; $display("[TB] FAIL hazard_release: got ready %b expected 1", obs_ready); end
        drain();
        checks++; if (bus.wb_reg_wr !== 1'b1) begin errors++; $display("[TB] FAIL hazard_dep_wr: got %b expected 1", bus.wb_reg_wr); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, 2'b00, 0, 0, 0, 0, 0, 0);
        checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL full_set: got %b expected 1", full); end
        step(1, 2'b00, 1, 0, 0, 1, 0, 0);
        checks++; if (obs_ready !== 1'b0 || obs_full !== 1'b1) begin errors++; $display("[TB] FAIL full_no_bypass: got ready=%b full=%b expected 0 1", obs_ready, obs_full); end
        checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL full_after_pop: got %b expected 0", full); end
        step(1, 2'b00, 1, 0, 0, 0, 0, 0);
        checks++; if (obs_ready !== 1'b1 || full !== 1'b1) begin errors++; $display("[TB] FAIL full_refill: got ready=%b full=%b expected 1 1", obs_ready, full); end
        drain();
    endtask

    task automatic test_underflow();
        do_reset();
        step(0, 2'b00, 0, 0, 0, 1, 1, 1);
        checks++; if (err_underflow !== 1'b1) begin errors++; $display("[TB] FAIL underflow_set: got %b expected 1", err_underflow); end
        checks++; if (bus.wb_valid !== 1'b0 || c_flag !== 1'b0 || z_flag !== 1'b0) begin errors++; $display("[TB] FAIL underflow_side: got v=%b c=%b z=%b expected 0 0 0", bus.wb_valid, c_flag, z_flag); end
        for (int i = 0; i < 3; i++) step(1, 2'b00, 1, 0, 0, (i == 1), 0, 0);
        checks++; if (err_underflow !== 1'b1) begin errors++; $display("[TB] FAIL underflow_sticky: got %b expected 1", err_underflow); end
        do_reset();
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("[TB] FAIL underflow_clear: got %b expected 0", err_underflow); end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        step(0, 2'b00, 0, 0, 0, 1, 0, 0);
        step(1, 2'b00, 1, 1, 1, 0, 0, 0);
        step(0, 2'b00, 0, 0, 0, 1, 1, 1);
        step(1, 2'b00, 1, 1, 0, 0, 0, 0);
        step(1, 2'b00, 1, 1, 0, 0, 0, 0);
        step(1, 2'b00, 1, 0, 1, 0, 0, 0);
        checks++; if (c_flag !== 1'b1 || err_underflow !== 1'b1) begin errors++; $display("[TB] FAIL inflight_pre: got c=%b err=%b expected 1 1", c_flag, err_underflow); end
        #2 reset = 1'b1;
        #1;
        model_clear();
        checks++; if ({c_flag, z_flag, err_underflow, full, bus.wb_valid, bus.wb_reg_wr} !== 6'b0) begin errors++; $display("[TB] FAIL inflight_async: got %b expected 000000", {c_flag, z_flag, err_underflow, full, bus.wb_valid, bus.wb_reg_wr}); end
        @(posedge clk);
        #1 reset = 1'b0;
        step(1, 2'b10, 1, 1, 0, 0, 0, 0);
        checks++; if (obs_ready !== 1'b1) begin errors++; $display("[TB] FAIL inflight_dep_ready: got %b expected 1", obs_ready); end
        step(0, 2'b00, 0, 0, 0, 1, 1, 0);
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_reg_wr !== 1'b0 || c_flag !== 1'b0) begin errors++; $display("[TB] FAIL inflight_dep_wb: got v=%b w=%b c=%b expected 1 0 0", bus.wb_valid, bus.wb_reg_wr, c_flag); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 9) < 7, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 9) < 4, 1'($urandom), 1'($urandom));
            checks++; if (obs_ready !== exp_ready) begin errors++; $display("[TB] FAIL rand_ready @%0d: got %b expected %b", n, obs_ready, exp_ready); end
            checks++; if (obs_full !== exp_full || full !== (m_q.size() == DEPTH)) begin errors++; $display("[TB] FAIL rand_full @%0d: got %b/%b expected %b/%b", n, obs_full, full, exp_full, m_q.size() == DEPTH); end
            checks++; if (bus.wb_valid !== m_wbv || bus.wb_reg_wr !== m_wbw) begin errors++; $display("[TB] FAIL rand_wb @%0d: got %b%b expected %b%b", n, bus.wb_valid, bus.wb_reg_wr, m_wbv, m_wbw); end
            checks++; if (c_flag !== m_c || z_flag !== m_z) begin errors++; $display("[TB] FAIL rand_flags @%0d: got c=%b z=%b expected c=%b z=%b", n, c_flag, z_flag, m_c, m_z); end
            checks++; if (err_underflow !== m_err) begin errors++; $display("[TB] FAIL rand_err @%0d: got %b expected %b", n, err_underflow, m_err); end
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_uncond_write();
        test_cond_skip();
        test_hazard();
        test_full();
        test_underflow();
        test_reset_inflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
